// File: rtl/servo_cmd_scheduler_if.sv
// Command/width bus between the state estimator, the scheduler and the PWM stage.
interface servo_cmd_scheduler_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_ch;
    logic [31:0] cmd_width;
    logic [31:0] width_ch1;
    logic [31:0] width_ch2;
    logic [31:0] width_ch3;
    logic [31:0] width_ch4;
    logic        frame_tick;
    logic        cmd_clamped;
    logic        wdt_timeout;

    modport master (
        output cmd_valid, cmd_ch, cmd_width,
        input  cmd_ready, width_ch1, width_ch2, width_ch3, width_ch4,
               frame_tick, cmd_clamped, wdt_timeout
    );

    modport slave (
        input  cmd_valid, cmd_ch, cmd_width,
        output cmd_ready, width_ch1, width_ch2, width_ch3, width_ch4,
               frame_tick, cmd_clamped, wdt_timeout
    );
endinterface

// File: rtl/servo_cmd_scheduler.sv
// Servo command scheduler: clamps incoming width commands, then once per PWM
// frame sweeps the four channels (one per cycle, ticks 0..3) slewing each
// applied width toward its target. Optional command watchdog is enabled by
// defining SERVO_CMD_WATCHDOG_EN.
module servo_cmd_scheduler #(
    parameter int unsigned PERIOD_TICKS = 2000000,
    parameter int unsigned MIN_WIDTH    = 100000,
    parameter int unsigned MAX_WIDTH    = 200000,
    parameter int unsigned NEUTRAL      = 150000,
    parameter int unsigned SLEW_STEP    = 2000
`ifdef SERVO_CMD_WATCHDOG_EN
    , parameter int unsigned WDT_FRAMES = 25
`endif
) (
    input logic                  clk,
    input logic                  rst,
    servo_cmd_scheduler_if.slave bus
);
    localparam int CW = $clog2(PERIOD_TICKS);

    typedef enum logic {IDLE, UPDATE} state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [1:0]    idx;
    logic [31:0]   tgt [4];
    logic [31:0]   cur [4];
    logic          ready_q;
    logic          clamped_q;
    logic          tick;
    logic          accept;
    logic [31:0]   clamped_w;

    assign tick   = (cnt == CW'(PERIOD_TICKS - 1));
    assign accept = bus.cmd_valid && ready_q;

    // Saturate the requested width into the safe range.
    always_comb begin
        clamped_w = bus.cmd_width;
        if (bus.cmd_width < MIN_WIDTH)
            clamped_w = MIN_WIDTH;
        else if (bus.cmd_width > MAX_WIDTH)
            clamped_w = MAX_WIDTH;
    end

    // Step toward the target by at most SLEW_STEP; difference taken only on the larger side.
    function automatic logic [31:0] slew(input logic [31:0] c, input logic [31:0] t);
        logic [31:0] d;
        if (t > c) begin
            d = t - c;
            return c + ((d > SLEW_STEP) ? SLEW_STEP : d);
        end else if (t < c) begin
            d = c - t;
            return c - ((d > SLEW_STEP) ? SLEW_STEP : d);
        end
        return c;
    endfunction

    // Frame counter, same period and reset as the PWM stage counter.
    always_ff @(posedge clk) begin
        if (!rst)
            cnt <= '0;
        else if (tick)
            cnt <= '0;
        else
            cnt <= cnt + 1'b1;
    end

`ifdef SERVO_CMD_WATCHDOG_EN
    logic [31:0] wdt_cnt;
    logic        wdt_q;
    logic        wdt_fire;

    // An accepted command in the frame_tick cycle keeps the watchdog fed.
    assign wdt_fire = tick && !accept && (wdt_cnt == WDT_FRAMES - 1);

    // Count command-free frames; saturate once the failsafe has fired.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wdt_cnt <= '0;
            wdt_q   <= 1'b0;
        end else if (accept) begin
            wdt_cnt <= '0;
            wdt_q   <= 1'b0;
        end else if (tick && wdt_cnt != WDT_FRAMES) begin
            wdt_cnt <= wdt_cnt + 32'd1;
            if (wdt_fire)
                wdt_q <= 1'b1;
        end
    end

    assign bus.wdt_timeout = wdt_q;
`else
    assign bus.wdt_timeout = 1'b0;
`endif

    // Target registers: last accepted command per channel wins.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < 4; i++)
                tgt[i] <= NEUTRAL;
            clamped_q <= 1'b0;
        end else begin
            clamped_q <= accept && (clamped_w != bus.cmd_width);
`ifdef SERVO_CMD_WATCHDOG_EN
            if (wdt_fire)
                for (int i = 0; i < 4; i++)
                    tgt[i] <= NEUTRAL;
`endif
            if (accept)
                tgt[bus.cmd_ch] <= clamped_w;
        end
    end

    // Sweep FSM: stall commands while the four channels are slewed in ticks 0..3.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= IDLE;
            idx     <= 2'd0;
            ready_q <= 1'b1;
            for (int i = 0; i < 4; i++)
                cur[i] <= NEUTRAL;
        end else begin
            case (state)
                IDLE: begin
                    if (tick) begin
                        state   <= UPDATE;
                        idx     <= 2'd0;
                        ready_q <= 1'b0;
                    end
                end
                UPDATE: begin
                    cur[idx] <= slew(cur[idx], tgt[idx]);
                    idx      <= idx + 2'd1;
                    if (idx == 2'd3) begin
                        state   <= IDLE;
                        ready_q <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.cmd_ready   = ready_q;
    assign bus.frame_tick  = tick;
    assign bus.cmd_clamped = clamped_q;
    assign bus.width_ch1   = cur[0];
    assign bus.width_ch2   = cur[1];
    assign bus.width_ch3   = cur[2];
    assign bus.width_ch4   = cur[3];
endmodule

// File: tb/tb_servo_cmd_scheduler.sv
// Bench for servo_cmd_scheduler: directed steps plus random command frames,
// checked against a frame-level model (targets, widths, watchdog idle count).
// Define SERVO_CMD_WATCHDOG_EN to exercise the watchdog build.
module tb_servo_cmd_scheduler;
    localparam int unsigned P    = 1000;
    localparam int unsigned MINW = 100;
    localparam int unsigned MAXW = 200;
    localparam int unsigned NEU  = 150;
    localparam int unsigned STEP = 10;
`ifdef SERVO_CMD_WATCHDOG_EN
    localparam int unsigned WDT  = 3;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   failures = 0;
    int   tb_tick = 0;

    int unsigned m_tgt [4];
    int unsigned m_w   [4];
    logic        m_to;
`ifdef SERVO_CMD_WATCHDOG_EN
    int          m_idle;
    logic        m_late;
`endif

    servo_cmd_scheduler_if ifc();

    servo_cmd_scheduler #(
        .PERIOD_TICKS(P), .MIN_WIDTH(MINW), .MAX_WIDTH(MAXW),
        .NEUTRAL(NEU), .SLEW_STEP(STEP)
`ifdef SERVO_CMD_WATCHDOG_EN
        , .WDT_FRAMES(WDT)
`endif
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(ifc)
    );

    always #5 clk = ~clk;

    // Bench time reference: tick position inside the current frame.
    always @(posedge clk) begin
        if (!rst)
            tb_tick <= 0;
        else
            tb_tick <= (tb_tick == int'(P) - 1) ? 0 : tb_tick + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_tick(input int t);
        int n = 0;
        do begin
            step();
            n++;
        end while (tb_tick != t && n < 3000);
        if (tb_tick != t) begin
            checks++;
            failures++;
            $error("FAIL wait_tick observed=%0d expected=%0d", tb_tick, t);
        end
    endtask

    function automatic int unsigned clampw(input int unsigned w);
        if (w < MINW) return MINW;
        if (w > MAXW) return MAXW;
        return w;
    endfunction

    function automatic int unsigned slew_m(input int unsigned c, input int unsigned t);
        int d;
        d = int'(t) - int'(c);
        if (d > int'(STEP))  d = int'(STEP);
        if (d < -int'(STEP)) d = -int'(STEP);
        return int'(c) + d;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            m_tgt[i] = NEU;
            m_w[i]   = NEU;
        end
        m_to = 1'b0;
`ifdef SERVO_CMD_WATCHDOG_EN
        m_idle = 0;
        m_late = 1'b0;
`endif
    endtask

    // Offer a command, wait for acceptance, check the clamp flag and record it in the model.
    task automatic send(input logic [1:0] ch, input int unsigned w, output int stalls);
        logic rdy;
        int   n = 0;
        stalls = 0;
        ifc.cmd_valid = 1'b1;
        ifc.cmd_ch    = ch;
        ifc.cmd_width = w;
        do begin
            rdy = ifc.cmd_ready;
            step();
            if (!rdy) stalls++;
            n++;
        end while (!rdy && n < 50);
        ifc.cmd_valid = 1'b0;
        if (!rdy) begin
            checks++;
            failures++;
            $error("FAIL accept_timeout observed=%0d expected=%0d", stalls, 4);
        end
        chk("cmd_clamped", 32'(ifc.cmd_clamped), 32'(clampw(w) != w));
        m_tgt[ch] = clampw(w);
        m_to = 1'b0;
`ifdef SERVO_CMD_WATCHDOG_EN
        m_idle = 0;
        if (tb_tick == 0) m_late = 1'b1;
`endif
    endtask

    // Model one frame boundary: watchdog bookkeeping, then one slew step per channel.
    task automatic boundary();
`ifdef SERVO_CMD_WATCHDOG_EN
        if (!m_late && m_idle < int'(WDT)) begin
            m_idle++;
            if (m_idle == int'(WDT)) begin
                m_to = 1'b1;
                for (int i = 0; i < 4; i++) m_tgt[i] = NEU;
            end
        end
        m_late = 1'b0;
`endif
        for (int i = 0; i < 4; i++) m_w[i] = slew_m(m_w[i], m_tgt[i]);
    endtask

    task automatic compare(input string tag);
        chk({tag, ".w1"}, ifc.width_ch1, m_w[0]);
        chk({tag, ".w2"}, ifc.width_ch2, m_w[1]);
        chk({tag, ".w3"}, ifc.width_ch3, m_w[2]);
        chk({tag, ".w4"}, ifc.width_ch4, m_w[3]);
        chk({tag, ".rdy"}, 32'(ifc.cmd_ready), 32'd1);
        chk({tag, ".wdt"}, 32'(ifc.wdt_timeout), 32'(m_to));
    endtask

    task automatic frame_check(input string tag);
        boundary();
        wait_tick(4);
        compare(tag);
    endtask

    initial begin
        int st;
        int ncmd;
        ifc.cmd_valid = 1'b0;
        ifc.cmd_ch    = 2'd0;
        ifc.cmd_width = 32'd0;
        model_reset();

        // 1. reset state and first frame_tick position
        rst = 1'b0;
        repeat (3) step();
        chk("rst.w1", ifc.width_ch1, NEU);
        chk("rst.w2", ifc.width_ch2, NEU);
        chk("rst.w3", ifc.width_ch3, NEU);
        chk("rst.w4", ifc.width_ch4, NEU);
        chk("rst.rdy", 32'(ifc.cmd_ready), 32'd1);
        chk("rst.ftick", 32'(ifc.frame_tick), 32'd0);
        chk("rst.clamp", 32'(ifc.cmd_clamped), 32'd0);
        chk("rst.wdt", 32'(ifc.wdt_timeout), 32'd0);
        rst = 1'b1;
        wait_tick(998);
        chk("ftick_998", 32'(ifc.frame_tick), 32'd0);
        step();
        chk("ftick_999", 32'(ifc.frame_tick), 32'd1);
        frame_check("idle");

        // 2. slew toward 180 in 10-tick steps
        send(2'd0, 180, st);
        frame_check("slew1");
        chk("slew_first", ifc.width_ch1, 32'd160);
        frame_check("slew2");
        frame_check("slew3");
        chk("slew_done", ifc.width_ch1, 32'd180);
        frame_check("slew_hold");

        // 3. clamping both ends, and an in-range value
        send(2'd2, 5000, st);
        send(2'd3, 0, st);
        send(2'd1, 150, st);
        frame_check("clamp1");
        frame_check("clamp2");

        // 4a. last accepted value wins
        send(2'd1, 120, st);
        send(2'd1, 190, st);
        frame_check("last_wins");
        chk("last_wins_w2", ifc.width_ch2, 32'd160);

        // 4b. command in the frame_tick cycle lands before the sweep
        wait_tick(999);
        send(2'd0, 100, st);
        frame_check("edge_cmd");

        // 4c. command held across frame_tick stalls for the 4 sweep cycles
        boundary();
        wait_tick(0);
        send(2'd2, 150, st);
        chk("stall_cycles", st, 32'd4);
        compare("stall");

        // random command frames
        for (int f = 0; f < 12; f++) begin
            ncmd = $urandom_range(0, 3);
            for (int c = 0; c < ncmd; c++)
                send(2'($urandom_range(0, 3)), $urandom_range(0, 300), st);
            frame_check("rand");
        end

        // 5. reset in the third sweep cycle
        send(2'd0, 200, st);
        send(2'd3, 100, st);
        frame_check("pre_rst1");
        frame_check("pre_rst2");
        wait_tick(2);
        rst = 1'b0;
        step();
        rst = 1'b1;
        model_reset();
        compare("mid_rst");
        repeat (998) step();
        chk("mid_rst_ftick0", 32'(ifc.frame_tick), 32'd0);
        step();
        chk("mid_rst_ftick1", 32'(ifc.frame_tick), 32'd1);
        frame_check("post_rst");

        // 6. no commands for several frames: watchdog failsafe or indefinite hold
        send(2'd0, 200, st);
        for (int f = 0; f < 7; f++) frame_check("quiet");
`ifdef SERVO_CMD_WATCHDOG_EN
        chk("wdt_set", 32'(ifc.wdt_timeout), 32'd1);
`else
        chk("hold_w1", ifc.width_ch1, 32'd200);
`endif
        send(2'd1, 120, st);
        chk("wdt_clear", 32'(ifc.wdt_timeout), 32'd0);
        frame_check("after_wdt");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
